alu_seq: RTL and testbench

// Parametrised, registered successor of the datapath ALU. Same Op encoding and invA/invB/Cin conventions,

---
 rtl/alu_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq : registered, multi-cycle datapath ALU for the EX stage.
//
// Single-cycle ops (shifts/rotates, ADD, logic, SLBI, BTR) finish one cycle after
// acceptance. MUL (shift-add) and DIV (restoring) iterate WIDTH times and present
// their result WIDTH+1 cycles after acceptance. Valid/ready on both sides; a
// finished result is held until the consumer takes it.
//
// Optional feature macro: ALU_SEQ_DIV_EN
//    defined   : Op 1011 is unsigned DIV (quotient on Out, remainder on Out_hi)
//    undefined : no divider hardware, Op 1011 behaves as an illegal op
//
// Ports
//    clk, rst             clock, synchronous active-high reset
//    in_valid / in_ready  operand handshake (accept when both high at clk edge)
//    A, B, Cin, Op        operands, adder carry-in, 4-bit opcode
//    invA, invB           invert A / B before use
//    sign                 ADD overflow mode (1 signed, 0 unsigned)
//    out_valid/out_ready  result handshake
//    Out, Out_hi          result, MUL high half / DIV remainder (0 otherwise)
//    OFL, Cout, Zero      overflow, adder carry-out, Out==0
// -----------------------------------------------------------------------------
module alu_seq #(
   parameter int WIDTH      = 24,
   parameter int SLBI_SHIFT = WIDTH / 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic [3:0]       Op,
   input  logic             invA,
   input  logic             invB,
   input  logic             sign,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Out,
   output logic [WIDTH-1:0] Out_hi,
   output logic             OFL,
   output logic             Cout,
   output logic             Zero
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   typedef struct packed {
      logic [WIDTH-1:0] out;
      logic [WIDTH-1:0] hi;
      logic             ofl;
      logic             cout;
   } res_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] a1, b1;
   logic             accept, multi;
   logic [WIDTH-1:0] opnd_p0;
   logic [WIDTH-1:0] acc_hi_p1, acc_lo_p1;
   logic [WIDTH-1:0] step_hi, step_lo;
   logic [WIDTH:0]   mul_sum;
   res_t             single;

   // Combinational result of every op that completes in one cycle.
   function automatic res_t alu_single(input logic [3:0]       op,
                                       input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b,
                                       input logic             cin,
                                       input logic             sgn);
      res_t             r;
      logic [CNT_W-1:0] shamt;
      logic [WIDTH:0]   sum;
      logic             ovf_s;
      r     = '0;
      shamt = CNT_W'(int'(b[CNT_W-1:0]) % WIDTH);
      sum   = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
      ovf_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      case (op)
         4'b0000: r.out = (a << shamt) | (a >> (WIDTH - int'(shamt)));
         4'b0001: r.out = a << shamt;
         4'b0010: r.out = (a >> shamt) | (a << (WIDTH - int'(shamt)));
         4'b0011: r.out = $unsigned($signed(a) >>> shamt);
         4'b0100: begin
            r.out  = sum[WIDTH-1:0];
            r.cout = sum[WIDTH];
            r.ofl  = sgn ? ovf_s : sum[WIDTH];
         end
         4'b0101: r.out = a | b;
         4'b0110: r.out = a ^ b;
         4'b0111: r.out = a & b;
         4'b1000: r.out = (a << SLBI_SHIFT) | b;
         4'b1001: for (int i = 0; i < WIDTH; i++) r.out[i] = a[WIDTH-1-i];
`ifdef ALU_SEQ_DIV_EN
         // Only reaches here with a zero divisor; a real divide iterates.
         4'b1011: begin
            r.out = '1;
            r.hi  = a;
            r.ofl = 1'b1;
         end
`endif
         default: r.ofl = 1'b1;
      endcase
      return r;
   endfunction

   assign a1     = A ^ {WIDTH{invA}};
   assign b1     = B ^ {WIDTH{invB}};
   assign single = alu_single(Op, a1, b1, Cin, sign);

`ifdef ALU_SEQ_DIV_EN
   logic           is_div_p0;
   logic [WIDTH:0] div_trial;
   assign multi = (Op == 4'b1010) || ((Op == 4'b1011) && (b1 != '0));
`else
   assign multi = (Op == 4'b1010);
`endif

   assign accept    = in_valid & in_ready;
   assign out_valid = (state == DONE);

   // ---- control: state register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (accept)
            cnt <= '0;
         else if (state == BUSY)
            cnt <= cnt + CNT_W'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = multi ? BUSY : DONE;
         end
         BUSY: if (cnt == CNT_W'(WIDTH-1)) state_nxt = DONE;
         DONE: begin
            if (out_ready) begin
               in_ready  = 1'b1;
               state_nxt = in_valid ? (multi ? BUSY : DONE) : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---- p1: one MUL/DIV iteration on the accumulator pair ----
   always_comb begin
      mul_sum = {1'b0, acc_hi_p1} + (acc_lo_p1[0] ? {1'b0, opnd_p0} : '0);
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_p1[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
      // Partial remainder always stays below the divisor, so WIDTH+1 bits hold
      // the trial difference without ambiguity.
      div_trial = {acc_hi_p1, acc_lo_p1[WIDTH-1]} - {1'b0, opnd_p0};
      if (is_div_p0) begin
         if (!div_trial[WIDTH]) begin
            step_hi = div_trial[WIDTH-1:0];
            step_lo = {acc_lo_p1[WIDTH-2:0], 1'b1};
         end else begin
            step_hi = {acc_hi_p1[WIDTH-2:0], acc_lo_p1[WIDTH-1]};
            step_lo = {acc_lo_p1[WIDTH-2:0], 1'b0};
         end
      end
`endif
   end

   // ---- p0: operand capture / iteration registers (no reset, data only) ----
   always_ff @(posedge clk) begin
      if (accept) begin
         acc_hi_p1 <= '0;
`ifdef ALU_SEQ_DIV_EN
         is_div_p0 <= Op[0];
         opnd_p0   <= Op[0] ? b1 : a1;
         acc_lo_p1 <= Op[0] ? a1 : b1;
`else
         opnd_p0   <= a1;
         acc_lo_p1 <= b1;
`endif
      end else if (state == BUSY) begin
         acc_hi_p1 <= step_hi;
         acc_lo_p1 <= step_lo;
      end
   end

   // ---- p2: result registers, written only when a result completes ----
   always_ff @(posedge clk) begin
      if (rst) begin
         Out    <= '0;
         Out_hi <= '0;
         OFL    <= 1'b0;
         Cout   <= 1'b0;
         Zero   <= 1'b0;
      end else if (accept && !multi) begin
         Out    <= single.out;
         Out_hi <= single.hi;
         OFL    <= single.ofl;
         Cout   <= single.cout;
         Zero   <= (single.out == '0);
      end else if ((state == BUSY) && (cnt == CNT_W'(WIDTH-1))) begin
         Out    <= step_lo;
         Out_hi <= step_hi;
`ifdef ALU_SEQ_DIV_EN
         OFL    <= !is_div_p0 && (step_hi != '0);
`else
         OFL    <= (step_hi != '0);
`endif
         Cout   <= 1'b0;
         Zero   <= (step_lo == '0);
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

   localparam int W   = 24;
   localparam int CW  = $clog2(W);
   localparam int SH  = W / 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] A = '0, B = '0;
   logic         Cin = 1'b0;
   logic [3:0]   Op = '0;
   logic         invA = 1'b0, invB = 1'b0, sign = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] Out, Out_hi;
   logic         OFL, Cout, Zero;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .Cin(Cin), .Op(Op), .invA(invA), .invB(invB), .sign(sign),
      .out_valid(out_valid), .out_ready(out_ready), .Out(Out), .Out_hi(Out_hi),
      .OFL(OFL), .Cout(Cout), .Zero(Zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] out;
      logic [W-1:0] hi;
      logic         ofl;
      logic         cout;
      logic         zero;
      int           lat;
      int           acc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   vcyc = 0;
   bit   new_item = 1'b1;
   bit   bp_rand = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: bit-level and integer arithmetic straight from the op definitions.
   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic ia, input logic ib, input logic sg);
      exp_t         e;
      logic [W-1:0] a1, b1;
      int           s;
      longint       sum, va, vb, vs, p;
      a1 = a ^ {W{ia}};
      b1 = b ^ {W{ib}};
      s  = int'(b1[CW-1:0]) % W;
      e.out = '0; e.hi = '0; e.ofl = 1'b0; e.cout = 1'b0; e.lat = 1; e.acc = 0;
      case (op)
         4'd0: for (int i = 0; i < W; i++) e.out[(i + s) % W] = a1[i];
         4'd1: for (int i = 0; i < W; i++) if (i + s < W) e.out[i + s] = a1[i];
         4'd2: for (int i = 0; i < W; i++) e.out[i] = a1[(i + s) % W];
         4'd3: for (int i = 0; i < W; i++) e.out[i] = (i + s < W) ? a1[i + s] : a1[W-1];
         4'd4: begin
            sum    = longint'(a1) + longint'(b1) + longint'(cin);
            e.out  = sum[W-1:0];
            e.cout = sum[W];
            va = a1[W-1] ? longint'(a1) - (longint'(1) << W) : longint'(a1);
            vb = b1[W-1] ? longint'(b1) - (longint'(1) << W) : longint'(b1);
            vs = va + vb + longint'(cin);
            e.ofl = sg ? ((vs > (longint'(1) << (W-1)) - 1) || (vs < -(longint'(1) << (W-1)))) : sum[W];
         end
         4'd5: e.out = a1 | b1;
         4'd6: e.out = a1 ^ b1;
         4'd7: e.out = a1 & b1;
         4'd8: begin
            p     = (longint'(a1) * (longint'(1) << SH)) | longint'(b1);
            e.out = p[W-1:0];
         end
         4'd9: for (int i = 0; i < W; i++) e.out[W-1-i] = a1[i];
         4'd10: begin
            p     = longint'(a1) * longint'(b1);
            e.out = p[W-1:0];
            e.hi  = p[2*W-1:W];
            e.ofl = (e.hi != 0);
            e.lat = W + 1;
         end
`ifdef ALU_SEQ_DIV_EN
         4'd11: begin
            if (b1 == 0) begin
               e.out = {W{1'b1}}; e.hi = a1; e.ofl = 1'b1;
            end else begin
               e.out = a1 / b1; e.hi = a1 % b1; e.lat = W + 1;
            end
         end
`endif
         default: e.ofl = 1'b1;
      endcase
      e.zero = (e.out == 0);
      return e;
   endfunction

   // Monitor: compares every result the consumer takes against the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid) begin
         if (new_item) begin
            vcyc     = cyc;
            new_item = 1'b0;
         end
         if (out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_output", 64'(out_valid), 64'(0));
            end else begin
               e = sb.pop_front();
               check("Out",     64'(Out),    64'(e.out));
               check("Out_hi",  64'(Out_hi), 64'(e.hi));
               check("OFL",     64'(OFL),    64'(e.ofl));
               check("Cout",    64'(Cout),   64'(e.cout));
               check("Zero",    64'(Zero),   64'(e.zero));
               check("latency", 64'(vcyc - e.acc + 1), 64'(e.lat));
            end
            new_item = 1'b1;
         end
      end
   end

   // Called at posedge+2; returns at posedge+2 after the accepting edge.
   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic ia, input logic ib, input logic sg,
                        output int waits);
      exp_t e;
      logic rdy;
      e = model(op, a, b, c, ia, ib, sg);
      Op = op; A = a; B = b; Cin = c; invA = ia; invB = ib; sign = sg;
      in_valid = 1'b1;
      waits = 0;
      forever begin
         if (bp_rand) out_ready = 1'($urandom_range(0, 1));
         #1 rdy = in_ready;
         @(posedge clk);
         if (rdy) break;
         waits++;
         if (waits > 200) begin
            $display("FAIL accept_timeout: got waits=%0d expected <=200", waits);
            $fatal(1, "accept timeout");
         end
         #2;
      end
      #1 e.acc = cyc;
      sb.push_back(e);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      out_ready = 1'b1;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      check("drain_empty", 64'(sb.size()), 64'(0));
      @(posedge clk);
      #2;
   endtask

   function automatic logic [W-1:0] rnd_val();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return {W{1'b1}};
         2:       return {1'b0, {(W-1){1'b1}}};
         3:       return {1'b1, {(W-1){1'b0}}};
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int   w;
      exp_t e;

      // reset state
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("rst_in_ready",  64'(in_ready),  64'(1));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_Out",       64'(Out),       64'(0));
      check("rst_Out_hi",    64'(Out_hi),    64'(0));
      check("rst_OFL",       64'(OFL),       64'(0));
      check("rst_Cout",      64'(Cout),      64'(0));
      check("rst_Zero",      64'(Zero),      64'(0));
      @(posedge clk); #2;

      // directed vectors
      issue(4'b0100, 24'h7FFFFF, 24'h000001, 1'b0, 1'b0, 1'b0, 1'b1, w);
      issue(4'b0100, 24'h000005, 24'h000005, 1'b1, 1'b0, 1'b1, 1'b0, w);
      issue(4'b1000, 24'h000ABC, 24'h000123, 1'b0, 1'b0, 1'b0, 1'b0, w);
      issue(4'b1001, 24'h000001, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, w);
      issue(4'b0011, 24'h800000, 24'h000004, 1'b0, 1'b0, 1'b0, 1'b0, w);
      issue(4'b0010, 24'h000001, 24'h000019, 1'b0, 1'b0, 1'b0, 1'b0, w);
      issue(4'b1010, 24'h001000, 24'h001000, 1'b0, 1'b0, 1'b0, 1'b0, w);
      issue(4'b1011, 24'd100,    24'd7,      1'b0, 1'b0, 1'b0, 1'b0, w);
      issue(4'b1011, 24'd100,    24'd0,      1'b0, 1'b0, 1'b0, 1'b0, w);
      issue(4'b1100, 24'h123456, 24'h654321, 1'b0, 1'b0, 1'b0, 1'b0, w);
      drain();

      // backpressure: result held, in_ready low, then accept on the release edge
      out_ready = 1'b0;
      e = model(4'b0100, 24'h123456, 24'h111111, 1'b0, 1'b0, 1'b0, 1'b0);
      issue(4'b0100, 24'h123456, 24'h111111, 1'b0, 1'b0, 1'b0, 1'b0, w);
      Op = 4'b0110; A = 24'h0F0F0F; B = 24'hFFFFFF; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("bp_in_ready",  64'(in_ready),  64'(0));
         check("bp_out_valid", 64'(out_valid), 64'(1));
         check("bp_Out",       64'(Out),       64'(e.out));
         #1;
      end
      out_ready = 1'b1;
      issue(4'b0110, 24'h0F0F0F, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, w);
      check("bp_same_edge_accept", 64'(w), 64'(0));
      drain();

      // in_valid during BUSY is dropped, not queued
      issue(4'b1010, 24'h000123, 24'h000456, 1'b0, 1'b0, 1'b0, 1'b0, w);
      Op = 4'b0100; A = 24'd1; B = 24'd1; in_valid = 1'b1;
      repeat (5) @(posedge clk);
      #2 in_valid = 1'b0;
      drain();
      repeat (3) @(posedge clk);
      #1 check("no_queued_op", 64'(out_valid), 64'(0));
      #1;

      // reset in the middle of a MUL
      issue(4'b1001, 24'h000001, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, w);
      drain();
      issue(4'b1010, 24'h000003, 24'h000005, 1'b0, 1'b0, 1'b0, 1'b0, w);
      repeat (9) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_in_ready",  64'(in_ready),  64'(1));
      check("midrst_out_valid", 64'(out_valid), 64'(0));
      check("midrst_Out",       64'(Out),       64'(0));
      sb.delete();
      #1 rst = 1'b0;
      issue(4'b0100, 24'd2, 24'd3, 1'b0, 1'b0, 1'b0, 1'b0, w);
      drain();

      // randomized traffic with random consumer stalls
      bp_rand = 1'b1;
      for (int n = 0; n < 200; n++) begin
         issue(4'($urandom_range(0, 15)), rnd_val(), rnd_val(), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
      end
      bp_rand = 1'b0;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
